// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared state encoding, default widths and frame-period helper for the DAC SPI driver
package dac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } dac_state_t;

    localparam int DDS_W       = 12;
    localparam int DAC_FRAME_W = 16;

    function automatic int frame_period(input int clk_div, input int frame_w, input int gap_cyc);
        return 1 + 2 * clk_div * frame_w + gap_cyc;
    endfunction

endpackage

// File: rtl/dac_sclk_gen.sv
// rtl/dac_sclk_gen.sv - SCLK divider producing the sclk level and an end-of-bit pulse
module dac_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  logic clr,
    output logic sclk,
    output logic bit_end
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             half_end;

    assign half_end = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign bit_end  = en && half_end && !sclk;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt <= '0;
            sclk    <= 1'b1;
        end else if (clr) begin
            div_cnt <= '0;
            sclk    <= 1'b1;
        end else if (en) begin
            if (half_end) begin
                div_cnt <= '0;
                sclk    <= ~sclk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_spi_driver.sv
// rtl/dac_spi_driver.sv - single-entry hold buffer and SPI framer for a DAC7512-class serial DAC
module dac_spi_driver
    import dac_pkg::*;
#(
    parameter int DATA_W  = DDS_W,
    parameter int FRAME_W = DAC_FRAME_W,
    parameter int CLK_DIV = 4,
    parameter int GAP_CYC = 2,
    parameter int TWOS_IN = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] din,
    input  logic              in_valid,
    output logic              dac_sclk,
    output logic              dac_sync_n,
    output logic              dac_sdin,
    output logic              busy,
    output logic [15:0]       drop_cnt
);

    localparam int BIT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    dac_state_t         state;
    dac_state_t         state_nxt;
    logic               hold_full;
    logic [FRAME_W-1:0] hold_data;
    logic [FRAME_W-1:0] frame_fmt;
    logic [FRAME_W-1:0] shift_reg;
    logic [BIT_W-1:0]   bit_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               consume;
    logic               bit_end;
    logic               last_bit;

    assign consume  = (state == ST_LOAD);
    assign last_bit = bit_end && (bit_cnt == '0);
    assign dac_sdin = shift_reg[FRAME_W-1];

    always_comb begin
        frame_fmt             = '0;
        frame_fmt[DATA_W-1:0] = din;
        if (TWOS_IN != 0) begin
            frame_fmt[DATA_W-1] = ~din[DATA_W-1];
        end
    end

    dac_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk     (clk),
        .rstn    (rstn),
        .en      (state == ST_SHIFT),
        .clr     (consume),
        .sclk    (dac_sclk),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (hold_full) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_nxt = ST_GAP;
            ST_GAP:   if (gap_cnt == '0) state_nxt = hold_full ? ST_LOAD : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_full <= 1'b0;
            hold_data <= '0;
            drop_cnt  <= '0;
        end else if (in_valid) begin
            hold_data <= frame_fmt;
            hold_full <= 1'b1;
            if (hold_full && !consume && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end else if (consume) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            dac_sync_n <= 1'b1;
            busy       <= 1'b0;
        end else begin
            busy <= (state_nxt != ST_IDLE);
            case (state)
                ST_LOAD: begin
                    shift_reg  <= hold_data;
                    bit_cnt    <= BIT_W'(FRAME_W - 1);
                    dac_sync_n <= 1'b0;
                end
                ST_SHIFT: begin
                    if (bit_end) begin
                        shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
                        bit_cnt   <= bit_cnt - 1'b1;
                        if (bit_cnt == '0) begin
                            dac_sync_n <= 1'b1;
                            gap_cnt    <= GAP_W'(GAP_CYC - 1);
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/dac_spi_driver.md
Name: dac_spi_driver

Overview:
- Downstream consumer of the phaser DDS sample stream (dout[11:0] / out_valid).
- Formats each 12-bit sample into a 16-bit serial frame and shifts it out to an external DAC7512-class SPI DAC (SCLK / SYNC_n / DIN).
- Holds one pending sample in a single-entry buffer. Samples that arrive faster than the frame rate overwrite the buffer and are counted as drops.

Parameters:
- DATA_W, 12: input sample width.
- FRAME_W, 16: serial frame width. Frame = {FRAME_W-DATA_W zero bits, sample}, MSB first.
- CLK_DIV, 4: clk cycles per SCLK half-period. Minimum 1.
- GAP_CYC, 2: clk cycles SYNC_n is held high between frames. Minimum 1.
- TWOS_IN, 1: 1 = input is two's complement; MSB is inverted to give offset binary. 0 = pass through unchanged.

Ports:
- clk, input, 1: system clock.
- rstn, input, 1: asynchronous active-low reset.
- din, input, DATA_W: sample from DDS.
- in_valid, input, 1: din is valid this cycle. There is no back-pressure.
- dac_sclk, output, 1: serial clock. Idles high.
- dac_sync_n, output, 1: frame sync, active low.
- dac_sdin, output, 1: serial data.
- busy, output, 1: high while the FSM is not in IDLE.
- drop_cnt, output, 16: count of overwritten samples. Saturates at 16'hFFFF.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - dac_sclk=1, dac_sync_n=1, dac_sdin=0, busy=0, drop_cnt=0.
  - Hold buffer empty, FSM in IDLE. Any partial frame is abandoned.
- Hold buffer:
  - When in_valid=1, the formatted sample is written into hold_data and hold_full is set the next cycle.
  - If hold_full=1 and the FSM is not consuming the buffer that same cycle, the old value is overwritten and drop_cnt increments (saturating).
  - If in_valid=1 in the same cycle the FSM consumes the buffer, the new sample is stored and hold_full stays 1. This is not a drop.
- FSM states: IDLE, LOAD, SHIFT, GAP.
  - IDLE: go to LOAD when hold_full=1.
  - LOAD (1 cycle):
    - Copy hold_data into the shift register; clear hold_full.
    - dac_sync_n goes low and dac_sdin shows frame bit FRAME_W-1 from the next cycle.
    - Load bit counter = FRAME_W-1; zero the divider counter.
  - SHIFT:
    - Each bit lasts 2*CLK_DIV cycles: first CLK_DIV cycles with sclk=1, then CLK_DIV cycles with sclk=0.
    - The DAC samples on the sclk falling edge, so sdin is stable for CLK_DIV cycles before and after it.
    - At the end of each bit the shift register moves left and the next bit appears on sdin.
    - After bit 0 completes, go to GAP.
  - GAP:
    - sync_n=1, sclk=1, sdin=0 for GAP_CYC cycles.
    - Then go to LOAD if hold_full=1, else IDLE.
- Timing:
  - Frame period = 1 + 2*CLK_DIV*FRAME_W + GAP_CYC clk cycles. Defaults give 131.
  - Latency from in_valid (cycle N) with FSM in IDLE: LOAD at N+2, sync_n low at N+3. A sample captured at N sets hold_full at N+1; IDLE sees it and moves to LOAD at N+2.
- All outputs are registered; no combinational path from inputs to outputs.
- Counters:
  - Divider is ceil(log2(CLK_DIV)) bits.
  - Bit counter is ceil(log2(FRAME_W)) bits.
  - GAP counter is ceil(log2(GAP_CYC+1)) bits.
- Formatting with TWOS_IN=1: din 12'h800 → 12'h000; 12'h7FF → 12'hFFF; 12'h000 → 12'h800.

Decomposition:
- Shared package dac_pkg:
  - State encoding localparams: ST_IDLE=0, ST_LOAD=1, ST_SHIFT=2, ST_GAP=3.
  - Defaults for DDS_W=12 and DAC_FRAME_W=16.
  - The frame-period constant function, for reuse by the bench.
- One natural sub-module, dac_sclk_gen: divider plus phase output (sclk level, bit_end pulse), enabled only in SHIFT.
- Sample formatting and the hold buffer stay inline.

Test Plan:
- Reset then a single sample: din=12'h123, in_valid one cycle, TWOS_IN=1 → one frame; SPI monitor captures 16'h0923 on sclk falling edges; sync_n low for exactly 128 cycles; busy falls 131 cycles after LOAD.
- Back-to-back at frame rate: in_valid every 131 cycles, 10 samples → 10 frames, no idle gap beyond GAP_CYC, drop_cnt=0.
- Overrun: in_valid every cycle for 300 cycles with incrementing din → frames carry only the latest held values; drop_cnt equals 300 minus samples consumed; monitor values are strictly increasing.
- Consume/write collision: assert in_valid exactly in the LOAD cycle → drop_cnt unchanged, the next frame carries the new sample.
- Reset mid-frame: deassert rstn at bit 7 → sync_n=1, sclk=1, sdin=0 immediately (asynchronous); after release, busy=0 and no frame is emitted until a new in_valid.
- Saturation and pass-through: force 70000 drops → drop_cnt holds 16'hFFFF. TWOS_IN=0 with din=12'h800 → frame 16'h0800.
